// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants and types for the round-robin shared-ALU arbiter.
package alu_share_arbiter_pkg;

  localparam int unsigned OPND_W = 4;
  localparam int unsigned RES_W  = 8;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD    = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB_AB = 2'b01;
  localparam logic [OP_W-1:0] OP_SUB_BA = 2'b10;
  localparam logic [OP_W-1:0] OP_MUL    = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu_4bit_core.sv
// Combinational 4-bit add/sub/mul unit producing an 8-bit result.
module alu_4bit_core
  import alu_share_arbiter_pkg::*;
(
  input  logic [OPND_W-1:0] a_i,
  input  logic [OPND_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [RES_W-1:0]  result_o
);

  logic [RES_W-1:0] a_ext;
  logic [RES_W-1:0] b_ext;

  assign a_ext = RES_W'(a_i);
  assign b_ext = RES_W'(b_i);

  // Select the operation; subtraction wraps modulo 256, multiply is unsigned.
  always_comb begin
    result_o = '0;
    unique case (op_i)
      OP_ADD:    result_o = a_ext + b_ext;
      OP_SUB_AB: result_o = a_ext - b_ext;
      OP_SUB_BA: result_o = b_ext - a_ext;
      OP_MUL:    result_o = a_ext * b_ext;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 4-bit ALU among NREQ requesters, one result slot.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned RR_RESET_PTR = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ-1:0][OPND_W-1:0]    req_a,
  input  logic [NREQ-1:0][OPND_W-1:0]    req_b,
  input  logic [NREQ-1:0][OP_W-1:0]      req_op,
  output logic [NREQ-1:0]                req_ready,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [RES_W-1:0]               rsp_result,
  output logic [$clog2(NREQ)-1:0]        rsp_id
);

  localparam int unsigned IDW = $clog2(NREQ);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic             grant_ok;
  logic             found;
  logic [IDW-1:0]   pick;
  logic             accept;
  logic [RES_W-1:0] alu_res;
  int unsigned      idx;

  // Grant window: idle, or holding a result that is being consumed this cycle.
  assign grant_ok = rst_n && ((state_q == ST_IDLE) || rsp_ready);

  // First valid requester at or after ptr, in circular order.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  assign accept = grant_ok && found;

  // One-hot grant to the picked requester.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[pick] = 1'b1;
  end

  alu_4bit_core u_alu (
    .a_i      (req_a[pick]),
    .b_i      (req_b[pick]),
    .op_i     (req_op[pick]),
    .result_o (alu_res)
  );

  // State, pointer and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= IDW'(RR_RESET_PTR);
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      rsp_result_q <= rsp_result_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  // Next-state: hold while a result is pending or a new one is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_HOLD;
      ST_HOLD: if (rsp_ready) state_d = accept ? ST_HOLD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath updates on acceptance; pointer advances past the granted requester.
  always_comb begin
    ptr_d        = ptr_q;
    rsp_result_d = rsp_result_q;
    rsp_id_d     = rsp_id_q;
    if (accept) begin
      rsp_result_d = alu_res;
      rsp_id_d     = pick;
      ptr_d        = (32'(pick) == NREQ - 1) ? '0 : IDW'(32'(pick) + 1);
    end
  end

  assign rsp_valid  = (state_q == ST_HOLD);
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter (NREQ=4, RR_RESET_PTR=0).
module tb_alu_share_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0][3:0]  req_a;
  logic [3:0][3:0]  req_b;
  logic [3:0][1:0]  req_op;
  logic [3:0]       req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic [1:0]       rsp_id;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] valid;
    int         idx;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] exp_ready;
    logic [7:0] exp_res;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[8];

  alu_share_arbiter #(.NREQ(4), .RR_RESET_PTR(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rsp(input string name, input logic [7:0] res, input logic [1:0] id);
    chk({name, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({name, ".result"}, 32'(rsp_result), 32'(res));
    chk({name, ".id"}, 32'(rsp_id), 32'(id));
  endtask

  initial begin
    vecs[0] = '{4'b0001, 0, 4'd3,  4'd5,  2'b00, 4'b0001, 8'h08, 2'd0};
    vecs[1] = '{4'b0001, 0, 4'd3,  4'd5,  2'b01, 4'b0001, 8'hFE, 2'd0};
    vecs[2] = '{4'b0001, 0, 4'd3,  4'd5,  2'b10, 4'b0001, 8'h02, 2'd0};
    vecs[3] = '{4'b0001, 0, 4'd15, 4'd15, 2'b11, 4'b0001, 8'hE1, 2'd0};
    vecs[4] = '{4'b0100, 2, 4'd9,  4'd7,  2'b00, 4'b0100, 8'h10, 2'd2};
    vecs[5] = '{4'b0010, 1, 4'd2,  4'd9,  2'b01, 4'b0010, 8'hF9, 2'd1};
    vecs[6] = '{4'b1000, 3, 4'd0,  4'd0,  2'b11, 4'b1000, 8'h00, 2'd3};
    vecs[7] = '{4'b1000, 3, 4'd15, 4'd0,  2'b10, 4'b1000, 8'hF1, 2'd3};

    // Reset with all requesters valid: no grant while rst_n is low.
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      req_a[j] = 4'hA; req_b[j] = 4'h5; req_op[j] = 2'b11;
    end
    @(negedge clk);
    @(negedge clk);
    #1 chk("reset.req_ready", 32'(req_ready), 32'd0);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_result", 32'(rsp_result), 32'd0);
    chk("reset.rsp_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: single-requester ALU ops, rsp_ready held high.
    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < 4; j++) begin
        req_a[j] = 4'hA; req_b[j] = 4'h5; req_op[j] = 2'b11;
      end
      req_valid = vecs[v].valid;
      req_a[vecs[v].idx] = vecs[v].a;
      req_b[vecs[v].idx] = vecs[v].b;
      req_op[vecs[v].idx] = vecs[v].op;
      #1 chk($sformatf("vec%0d.req_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
      @(negedge clk);
      chk_rsp($sformatf("vec%0d", v), vecs[v].exp_res, vecs[v].exp_id);
    end

    // Holding with rsp_ready and no request: drop to idle.
    req_valid = 4'b0000;
    #1 chk("drain.req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("drain.rsp_valid", 32'(rsp_valid), 32'd0);

    // All four valid back-to-back: grants 0,1,2,3,0.
    for (int j = 0; j < 4; j++) begin
      req_a[j] = 4'(j + 1); req_b[j] = 4'd2; req_op[j] = 2'b00;
    end
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1 chk($sformatf("rr%0d.req_ready", g), 32'(req_ready), 32'(4'b0001 << (g % 4)));
      @(negedge clk);
      chk_rsp($sformatf("rr%0d", g), 8'((g % 4) + 3), 2'(g % 4));
    end

    // Stall while holding id 2: no grants, result stable, then grant moves to 3.
    req_valid = 4'b0100;
    req_a[2] = 4'd6; req_b[2] = 4'd3; req_op[2] = 2'b11;
    #1 chk("stall.grant2", 32'(req_ready), 32'b0100);
    @(negedge clk);
    chk_rsp("stall.hold2", 8'h12, 2'd2);
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1 chk($sformatf("stall%0d.req_ready", c), 32'(req_ready), 32'd0);
      @(negedge clk);
      chk_rsp($sformatf("stall%0d", c), 8'h12, 2'd2);
    end
    rsp_ready = 1'b1;
    #1 chk("stall.release", 32'(req_ready), 32'b1000);
    @(negedge clk);
    chk_rsp("stall.after", 8'h06, 2'd3);

    // Pointer wrap: ptr=1 with 1001 grants 3, then wraps to 0.
    req_valid = 4'b0001;
    #1 chk("wrap.pre", 32'(req_ready), 32'b0001);
    @(negedge clk);
    chk_rsp("wrap.pre", 8'h03, 2'd0);
    req_valid = 4'b1001;
    #1 chk("wrap.grant3", 32'(req_ready), 32'b1000);
    @(negedge clk);
    chk_rsp("wrap.r3", 8'h06, 2'd3);
    #1 chk("wrap.grant0", 32'(req_ready), 32'b0001);
    @(negedge clk);
    chk_rsp("wrap.r0", 8'h03, 2'd0);

    // Reset while holding: result discarded, pointer back to reset value.
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1 chk("hold_rst.req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("hold_rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("hold_rst.rsp_result", 32'(rsp_result), 32'd0);
    chk("hold_rst.rsp_id", 32'(rsp_id), 32'd0);
    rsp_ready = 1'b1;
    #1 chk("hold_rst.grant", 32'(req_ready), 32'b0001);
    @(negedge clk);
    chk_rsp("hold_rst.r0", 8'h03, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
